// File: rtl/dmem_responder.sv
// dmem_responder: behavioural data memory / responder for the M-stage data port.
// Accepts one mem_read or mem_write request at a time, acks it exactly LATENCY
// cycles after the accept cycle, and exports a combinational stall for the
// hazard unit while the access is outstanding.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   mem_read, mem_write     request lines, held by the requester until ack
//   address, write_data     word address (low ADDR_WIDTH bits used), store data
//   read_data               load result, valid from the read ack cycle onward
//   ack                     one-cycle completion pulse
//   busy                    transaction latched and not yet acked
//   stall                   (mem_read | mem_write) & ~ack
//   protocol_err            sticky: read and write both high at accept
//   txn_count               completed transactions, wraps at 2^16
module dmem_responder #(
    parameter int WORD_SIZE  = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [WORD_SIZE-1:0] address,
    input  logic [WORD_SIZE-1:0] write_data,
    output logic [WORD_SIZE-1:0] read_data,
    output logic                 ack,
    output logic                 busy,
    output logic                 stall,
    output logic                 protocol_err,
    output logic [15:0]          txn_count
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    // WAIT spans cycles k+1 .. k+LATENCY-1, i.e. LATENCY-1 cycles; the counter
    // is loaded with LATENCY-2 and RESP is entered after it reaches zero.
    localparam logic [3:0] WAIT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t                  state, state_nxt;
    logic [3:0]              cnt, cnt_nxt;
    logic                    op_wr;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [WORD_SIZE-1:0]    wdata;
    logic [WORD_SIZE-1:0]    mem [2**ADDR_WIDTH];

    logic                    req;
    logic                    accept;
    logic [ADDR_WIDTH-1:0]   cur_idx;
    logic                    cur_rd;
    logic                    unused_addr_hi;

    assign req    = mem_read | mem_write;
    assign accept = (state == S_IDLE) && req;

    // Upper address bits alias onto the same word.
    assign unused_addr_hi = ^address[WORD_SIZE-1:ADDR_WIDTH];

    // Index/op of the transaction that will be in RESP next cycle: straight
    // from the inputs when accepting, otherwise the latched copy.
    assign cur_idx = (state == S_IDLE) ? address[ADDR_WIDTH-1:0] : idx;
    assign cur_rd  = (state == S_IDLE) ? ~mem_write : ~op_wr;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (req) begin
                    state_nxt = (LATENCY > 1) ? S_WAIT : S_RESP;
                    cnt_nxt   = WAIT_LOAD;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) state_nxt = S_RESP;
                else             cnt_nxt   = cnt - 4'd1;
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        ack   = (state == S_RESP);
        busy  = (state != S_IDLE);
        stall = req & ~ack;
    end

    // Transaction latch, status and load result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_wr        <= 1'b0;
            idx          <= '0;
            wdata        <= '0;
            read_data    <= '0;
            protocol_err <= 1'b0;
            txn_count    <= 16'd0;
        end else begin
            if (accept) begin
                op_wr <= mem_write;     // read+write collapses to a write
                idx   <= address[ADDR_WIDTH-1:0];
                wdata <= write_data;
                if (mem_read && mem_write) protocol_err <= 1'b1;
            end
            // Loading on entry to RESP makes the result visible during the ack
            // cycle; the array cannot change in between since writes only
            // commit at the end of RESP.
            if (state_nxt == S_RESP && state != S_RESP && cur_rd)
                read_data <= mem[cur_idx];
            if (state == S_RESP)
                txn_count <= txn_count + 16'd1;
        end
    end

    // Array is deliberately not reset; contents survive reset_n.
    always_ff @(posedge clk) begin
        if (state == S_RESP && op_wr)
            mem[idx] <= wdata;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: self-checking bench for dmem_responder. Two instances
// (LATENCY 4 and LATENCY 1) are driven by directed and random transactions
// and compared each cycle against a transaction-level reference model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd     [2];
    logic        wr     [2];
    logic [15:0] addr   [2];
    logic [15:0] wdat   [2];
    logic [15:0] rdata_o[2];
    logic        ack_o  [2];
    logic        busy_o [2];
    logic        stall_o[2];
    logic        perr_o [2];
    logic [15:0] cnt_o  [2];

    // Reference model state
    logic [15:0] mem_m  [2][256];
    logic [15:0] rdata_m[2];
    logic [15:0] cnt_m  [2];
    logic        perr_m [2];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.WORD_SIZE(16), .ADDR_WIDTH(8), .LATENCY(4)) dut4 (
        .clk(clk), .reset_n(rst_n), .mem_read(rd[0]), .mem_write(wr[0]),
        .address(addr[0]), .write_data(wdat[0]), .read_data(rdata_o[0]),
        .ack(ack_o[0]), .busy(busy_o[0]), .stall(stall_o[0]),
        .protocol_err(perr_o[0]), .txn_count(cnt_o[0]));

    dmem_responder #(.WORD_SIZE(16), .ADDR_WIDTH(8), .LATENCY(1)) dut1 (
        .clk(clk), .reset_n(rst_n), .mem_read(rd[1]), .mem_write(wr[1]),
        .address(addr[1]), .write_data(wdat[1]), .read_data(rdata_o[1]),
        .ack(ack_o[1]), .busy(busy_o[1]), .stall(stall_o[1]),
        .protocol_err(perr_o[1]), .txn_count(cnt_o[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input int s);
        chk("read_data", rdata_o[s], rdata_m[s]);
        chk("txn_count", cnt_o[s], cnt_m[s]);
        chk("protocol_err", perr_o[s], perr_m[s]);
    endtask

    // Entered and left at #1 after a rising edge. Checks every cycle from the
    // request cycle k to the ack cycle k+lat; leaves request lines as they are
    // so consecutive calls model a continuously held request.
    task automatic txn(input int s, input bit r, input bit w,
                       input logic [15:0] a, input logic [15:0] d, input bit drop);
        int lat;
        bit req_on;
        logic [7:0] i;
        lat = (s == 0) ? 4 : 1;
        i = a[7:0];
        rd[s] = r; wr[s] = w; addr[s] = a; wdat[s] = d; req_on = 1;
        for (int c = 0; c <= lat; c++) begin
            if (drop && c == 1 && lat > 1) begin
                rd[s] = 0; wr[s] = 0;
                addr[s] = 16'($urandom); wdat[s] = 16'($urandom);
                req_on = 0;
            end
            if (c == 1 && r && w) perr_m[s] = 1'b1;
            if (c == lat && r && !w) rdata_m[s] = mem_m[s][i];
            @(negedge clk);
            chk("stall", stall_o[s], (req_on && c < lat));
            chk("ack", ack_o[s], (c == lat));
            chk("busy", busy_o[s], (c >= 1));
            chk_status(s);
            @(posedge clk); #1;
        end
        cnt_m[s] = cnt_m[s] + 16'd1;
        if (w) mem_m[s][i] = d;
    endtask

    task automatic idle(input int s, input int n);
        rd[s] = 0; wr[s] = 0;
        repeat (n) begin
            @(negedge clk);
            chk("idle_stall", stall_o[s], 0);
            chk("idle_ack", ack_o[s], 0);
            chk("idle_busy", busy_o[s], 0);
            chk_status(s);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] rnd;
        logic [15:0] a;
        int op, gap;

        rst_n = 0;
        for (int s = 0; s < 2; s++) begin
            rd[s] = 0; wr[s] = 0; addr[s] = 0; wdat[s] = 0;
            rdata_m[s] = 0; cnt_m[s] = 0; perr_m[s] = 0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_ack", ack_o[s], 0);
            chk("rst_busy", busy_o[s], 0);
            chk("rst_stall", stall_o[s], 0);
            chk_status(s);
        end
        @(posedge clk); #1;
        rst_n = 1;
        idle(0, 3);

        // LATENCY 4: write, read back, read_data held across a write
        txn(0, 0, 1, 16'h0010, 16'h1234, 0);
        idle(0, 1);
        chk("cnt_after_first", cnt_o[0], 1);
        txn(0, 1, 0, 16'h0010, 16'h0000, 0);
        idle(0, 1);
        txn(0, 0, 1, 16'h0020, 16'hBEEF, 0);
        idle(0, 2);
        // Aliasing on upper address bits
        txn(0, 1, 0, 16'h0110, 16'h0000, 0);
        txn(0, 1, 0, 16'h0020, 16'h0000, 0);
        idle(0, 1);

        // Reset during WAIT: no ack, pending write dropped
        txn(0, 0, 1, 16'h0030, 16'h0F0F, 0);
        rd[0] = 0; wr[0] = 1; addr[0] = 16'h0030; wdat[0] = 16'hAAAA;   // cycle k
        @(posedge clk); #1;                                             // WAIT 1
        @(posedge clk); #1;                                             // WAIT 2
        rst_n = 0;
        #1;
        chk("rst_mid_busy", busy_o[0], 0);
        chk("rst_mid_ack", ack_o[0], 0);
        rd[0] = 0; wr[0] = 0;
        for (int s = 0; s < 2; s++) begin
            rdata_m[s] = 0; cnt_m[s] = 0; perr_m[s] = 0;
        end
        repeat (2) begin
            @(negedge clk);
            chk("rst_mid_ack_hold", ack_o[0], 0);
            chk("rst_mid_busy_hold", busy_o[0], 0);
            chk_status(0);
            @(posedge clk); #1;
        end
        rst_n = 1;
        idle(0, 6);
        txn(0, 1, 0, 16'h0030, 16'h0000, 0);
        idle(0, 1);

        // Read and write together: performed as a write, sticky error
        txn(0, 1, 1, 16'h0040, 16'h5555, 0);
        idle(0, 1);
        txn(0, 1, 0, 16'h0040, 16'h0000, 0);
        idle(0, 2);

        // Random traffic: seed a small index set, then mixed ops with aliased
        // upper bits, occasional mid-WAIT request drops and idle gaps
        for (int j = 0; j < 8; j++) begin
            rnd = 16'($urandom);
            txn(0, 0, 1, 16'(16'h0050 + j), rnd, 0);
        end
        for (int j = 0; j < 40; j++) begin
            rnd = 16'($urandom);
            a = {rnd[15:8], 8'(8'h50 + $urandom_range(0, 7))};
            rnd = 16'($urandom);
            op = $urandom_range(0, 4);
            txn(0, (op != 1 && op != 2), (op == 1 || op == 2 || op == 4), a, rnd,
                ($urandom_range(0, 3) == 0));
            gap = $urandom_range(0, 2);
            if (gap > 0) idle(0, gap);
        end
        idle(0, 1);

        // LATENCY 1: back-to-back with the request held continuously
        idle(1, 1);
        txn(1, 0, 1, 16'h0010, 16'hC001, 0);
        txn(1, 0, 1, 16'h0011, 16'hC002, 0);
        txn(1, 1, 0, 16'h0010, 16'h0000, 0);
        txn(1, 1, 0, 16'h0011, 16'h0000, 0);
        txn(1, 1, 0, 16'h0111, 16'h0000, 0);
        txn(1, 1, 0, 16'h0010, 16'h0000, 0);
        idle(1, 2);

        // Counter wrap
        force dut1.txn_count = 16'hFFFF;
        #1;
        release dut1.txn_count;
        cnt_m[1] = 16'hFFFF;
        txn(1, 1, 0, 16'h0011, 16'h0000, 0);
        idle(1, 1);
        chk("cnt_wrap", cnt_o[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
